// File: rtl/uart_rx_ctrl.sv
// UART receiver: synchronizes rx_async, oversamples each bit at its centre,
// and presents each received word (with frame/parity status) on a valid/ready port.
//
// Ports:
//   clk         clock, all state updates on its rising edge
//   rst_n       asynchronous active-low reset
//   rx_async    serial line, idle high, unsynchronized
//   baud_tick   one-cycle enable at OVERSAMPLE x baud rate
//   parity_en   frame carries a parity bit (latched at start-bit confirm)
//   parity_odd  1 = odd parity, 0 = even (latched at start-bit confirm)
//   data_out    received word, LSB received first
//   data_valid  data_out holds an unconsumed word
//   data_ready  consumer accepts data_out when data_valid && data_ready
//   frame_err   stop bit was sampled low for the word in data_out
//   parity_err  parity mismatch for the word in data_out
//   overrun     a pending word was overwritten before acceptance
//   busy        receiver is inside a frame (START..STOP)
module uart_rx_ctrl #(
  parameter int DATA_BITS       = 8,
  parameter int OVERSAMPLE      = 16,
  parameter int NUM_SYNC_STAGES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_async,
  input  logic                 baud_tick,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF =
    CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL =
    CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LASTB =
    BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [NUM_SYNC_STAGES-1:0] r_sync;
  logic                       w_rx_s;

  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_pen;
  logic                 r_podd;
  logic                 r_perr;

  logic w_half;
  logic w_full;
  logic w_cnt_clr;
  logic w_confirm;
  logic w_shift;
  logic w_par_smp;
  logic w_done;
  logic w_accept;

  // Synchronizer resets to 0 so the FSM must see the line
  // high (WAIT_IDLE) before it can arm on a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[NUM_SYNC_STAGES-2:0], rx_async};
    end
  end

  assign w_rx_s = r_sync[NUM_SYNC_STAGES-1];

  assign w_half   = baud_tick && (r_cnt == HALF);
  assign w_full   = baud_tick && (r_cnt == FULL);
  assign w_accept = data_valid && data_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_confirm   = 1'b0;
    w_shift     = 1'b0;
    w_par_smp   = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      WAIT_IDLE: begin
        w_cnt_clr = 1'b1;
        if (w_rx_s) begin
          w_state_nxt = IDLE;
        end
      end
      IDLE: begin
        w_cnt_clr = 1'b1;
        if (!w_rx_s) begin
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_half) begin
          w_cnt_clr = 1'b1;
          if (w_rx_s) begin
            w_state_nxt = IDLE;
          end else begin
            w_confirm   = 1'b1;
            w_state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (w_full) begin
          w_shift = 1'b1;
          if (r_bit == LASTB) begin
            w_state_nxt = r_pen ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (w_full) begin
          w_par_smp   = 1'b1;
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_full) begin
          w_done      = 1'b1;
          w_state_nxt = w_rx_s ? IDLE : WAIT_IDLE;
        end
      end
      default: begin
        w_state_nxt = WAIT_IDLE;
      end
    endcase
  end

  // Tick counter wraps explicitly so non-power-of-2
  // OVERSAMPLE values keep a full bit period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_cnt_clr || w_full) begin
      r_cnt <= '0;
    end else if (baud_tick) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit <= '0;
    end else if (w_confirm) begin
      r_bit <= '0;
    end else if (w_shift) begin
      r_bit <= r_bit + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
    end else if (w_shift) begin
      r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
    end
  end

  // Parity mode is frozen for the whole frame at confirm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pen  <= 1'b0;
      r_podd <= 1'b0;
      r_perr <= 1'b0;
    end else if (w_confirm) begin
      r_pen  <= parity_en;
      r_podd <= parity_odd;
      r_perr <= 1'b0;
    end else if (w_par_smp) begin
      r_perr <= ((^r_shift) ^ w_rx_s) != r_podd;
    end
  end

  // A completing frame always wins over acceptance; it
  // only counts as overrun if the old word was refused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else if (w_done) begin
      data_out   <= r_shift;
      data_valid <= 1'b1;
      frame_err  <= !w_rx_s;
      parity_err <= r_perr;
      overrun    <= data_valid && !data_ready;
    end else if (w_accept) begin
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end
  end

  assign busy = r_state inside {START, DATA, PARITY, STOP};

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl (8 data bits, 16x oversample,
// baud_tick every cycle): vector table plus corner sequences.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_async;
  logic       baud_tick;
  logic       parity_en;
  logic       parity_odd;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;

  uart_rx_ctrl #(
    .DATA_BITS(8),
    .OVERSAMPLE(16),
    .NUM_SYNC_STAGES(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_async(rx_async),
    .baud_tick(baud_tick),
    .parity_en(parity_en),
    .parity_odd(parity_odd),
    .data_out(data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .frame_err(frame_err),
    .parity_err(parity_err),
    .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       pen;
    logic       podd;
    logic       pbit;
    logic       stop;
    logic [7:0] exp_d;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic chk_word(input string nm,
                          input logic [7:0] d,
                          input logic fe,
                          input logic pe,
                          input logic ov);
    chk({nm, ".valid"}, 32'(data_valid), 32'd1);
    chk({nm, ".data"}, 32'(data_out), 32'(d));
    chk({nm, ".ferr"}, 32'(frame_err), 32'(fe));
    chk({nm, ".perr"}, 32'(parity_err), 32'(pe));
    chk({nm, ".ovr"}, 32'(overrun), 32'(ov));
  endtask

  // Called at a negedge; returns at the negedge that ends
  // the last data/parity bit. flip toggles the parity
  // controls right after the start bit.
  task automatic send_head(input logic [7:0] d,
                           input logic wpar,
                           input logic pbit,
                           input logic flip);
    rx_async = 1'b0;
    repeat (16) @(negedge clk);
    if (flip) begin
      parity_en  = !parity_en;
      parity_odd = !parity_odd;
    end
    for (int i = 0; i < 8; i++) begin
      rx_async = d[i];
      repeat (16) @(negedge clk);
    end
    if (wpar) begin
      rx_async = pbit;
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic wpar,
                            input logic pbit,
                            input logic stop,
                            input logic flip);
    send_head(d, wpar, pbit, flip);
    rx_async = stop;
    repeat (16) @(negedge clk);
  endtask

  task automatic accept(input string nm);
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    chk({nm, ".acc_valid"}, 32'(data_valid), 32'd0);
    chk({nm, ".acc_ovr"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_seen;

    vt[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vt[1] = '{8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1};
    vt[2] = '{8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
    vt[3] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};
    vt[4] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1};
    vt[5] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vt[6] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
    vt[7] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[8] = '{8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b0};

    rst_n      = 1'b0;
    rx_async   = 1'b1;
    baud_tick  = 1'b1;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    data_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs",
        {data_out, data_valid, frame_err,
         parity_err, overrun, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // False start: low for 5 ticks; START is entered 4
    // cycles after the edge and left on the 8th tick.
    rx_async = 1'b0;
    repeat (3) @(negedge clk);
    chk("lat_busy_p3", 32'(busy), 32'd0);
    @(negedge clk);
    chk("lat_busy_p4", 32'(busy), 32'd1);
    @(negedge clk);
    rx_async = 1'b1;
    repeat (6) @(negedge clk);
    chk("fs_busy_p11", 32'(busy), 32'd1);
    @(negedge clk);
    chk("fs_busy_p12", 32'(busy), 32'd0);
    chk("fs_valid", 32'(data_valid), 32'd0);
    repeat (10) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      parity_en  = vt[i].pen;
      parity_odd = vt[i].podd;
      send_frame(vt[i].d, vt[i].pen, vt[i].pbit,
                 vt[i].stop, 1'b0);
      rx_async = 1'b1;
      chk_word($sformatf("vec%0d", i), vt[i].exp_d,
               vt[i].exp_fe, vt[i].exp_pe, 1'b0);
      chk($sformatf("vec%0d.busy", i), 32'(busy), 32'd0);
      accept($sformatf("vec%0d", i));
      repeat (20) @(negedge clk);
    end

    // Stop bit low, line stays low: no re-arm until high.
    parity_en = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_word("brk", 8'h3C, 1'b1, 1'b0, 1'b0);
    accept("brk");
    busy_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    chk("brk_no_start", 32'(busy_seen), 32'd0);
    chk("brk_no_valid", 32'(data_valid), 32'd0);
    rx_async = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(8'h96, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_word("brk_next", 8'h96, 1'b0, 1'b0, 1'b0);
    accept("brk_next");
    repeat (10) @(negedge clk);

    // Two unaccepted words: second overwrites, overrun set.
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_word("ovr", 8'h22, 1'b0, 1'b0, 1'b1);
    accept("ovr");
    repeat (10) @(negedge clk);

    // Acceptance on the completion cycle: no overrun.
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    send_head(8'h44, 1'b0, 1'b0, 1'b0);
    rx_async = 1'b1;
    repeat (11) @(negedge clk);
    chk("same_pre", 32'(data_out), 32'h11);
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    chk_word("same", 8'h44, 1'b0, 1'b0, 1'b0);
    accept("same");
    repeat (10) @(negedge clk);

    // Parity controls changed mid-frame are ignored.
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    send_frame(8'h03, 1'b0, 1'b0, 1'b1, 1'b1);
    rx_async = 1'b1;
    chk_word("flip_off", 8'h03, 1'b0, 1'b0, 1'b0);
    accept("flip_off");
    repeat (10) @(negedge clk);
    parity_en  = 1'b1;
    parity_odd = 1'b0;
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b1);
    rx_async = 1'b1;
    chk_word("flip_on", 8'h03, 1'b0, 1'b1, 1'b0);
    accept("flip_on");
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    repeat (10) @(negedge clk);

    // Reset in the middle of DATA with a word pending.
    send_frame(8'h77, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    rx_async = 1'b0;
    repeat (56) @(negedge clk);
    chk("rst_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs",
        {data_out, data_valid, frame_err,
         parity_err, overrun, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy || data_valid) busy_seen++;
    end
    chk("rst_low_ignored", 32'(busy_seen), 32'd0);
    rx_async = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_word("rst_next", 8'h81, 1'b0, 1'b0, 1'b0);
    accept("rst_next");
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
